// File: rtl/timebase_ctrl_if.sv
// ---------------------------------------------------------------------------
// timebase_ctrl_if : command handshake channel into the stopwatch timebase
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface timebase_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/timebase_ctrl.sv
// ---------------------------------------------------------------------------
// timebase_ctrl : run/pause/clear sequencer with tick and display-scan enables
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timebase_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1000,
  parameter int SCAN_DIV = 4,
  parameter int DIGITS   = 4
) (
  input  wire logic        clkin,
  input  wire logic        rst_n,
  timebase_ctrl_if.slave   cmd,
  output logic             tick,
  output logic             running,
  output logic [15:0]      elapsed,
  output logic             ovf,
  output logic             scan_en,
  output logic [1:0]       scan_sel
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int RPW = $clog2(DIV);
  localparam int SPW = $clog2(SCAN_DIV) + 1;

  localparam logic [RPW-1:0] c_RP_INIT  = RPW'(DIV - 1);
  localparam logic [SPW-1:0] c_SP_INIT  = SPW'(SCAN_DIV - 1);
  localparam logic [1:0]     c_SEL_LAST = 2'(DIGITS - 1);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RUN      = 2'd1;
  localparam logic [1:0] c_PAUSED   = 2'd2;
  localparam logic [1:0] c_CLEARING = 2'd3;

  generate
    if (DIV < 2) begin : g_div_check
      $error("timebase_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (SCAN_DIV < 1) begin : g_scan_check
      $error("timebase_ctrl: SCAN_DIV must be at least 1");
    end
    if (DIGITS < 2 || DIGITS > 4) begin : g_digits_check
      $error("timebase_ctrl: DIGITS must be in 2..4");
    end
  endgenerate

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [RPW-1:0] r_rp;
  logic [SPW-1:0] r_sp;
  logic           r_tick;
  logic           r_running;
  logic [15:0]    r_elapsed;
  logic           r_ovf;
  logic           r_scan_en;
  logic [1:0]     r_scan_sel;

  logic w_ready;
  logic w_acc;
  logic w_start;
  logic w_stop;
  logic w_clear;
  logic w_rp_zero;

  assign w_ready   = (r_state != c_CLEARING);
  assign w_acc     = cmd.cmd_valid && w_ready;
  assign w_start   = w_acc && (cmd.cmd_op == 2'b01);
  assign w_stop    = w_acc && (cmd.cmd_op == 2'b10);
  assign w_clear   = w_acc && (cmd.cmd_op == 2'b11);
  assign w_rp_zero = (r_rp == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_PAUSED: begin
        if (w_clear)      w_state_nxt = c_CLEARING;
        else if (w_start) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (w_clear)      w_state_nxt = c_CLEARING;
        else if (w_stop)  w_state_nxt = c_PAUSED;
      end
      c_CLEARING:         w_state_nxt = c_IDLE;
      default:            w_state_nxt = c_IDLE;
    endcase
  end

  // A CLEAR accepted on the terminal-count edge suppresses that edge's tick.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_rp      <= c_RP_INIT;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_elapsed <= 16'd0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (r_state == c_RUN);
      r_tick    <= (r_state == c_RUN) && w_rp_zero && !w_clear;
      if (w_clear) begin
        r_elapsed <= 16'd0;
        r_ovf     <= 1'b0;
        r_rp      <= c_RP_INIT;
      end else if (r_state == c_RUN) begin
        if (w_rp_zero) begin
          r_rp      <= c_RP_INIT;
          r_elapsed <= r_elapsed + 16'd1;
          if (r_elapsed == 16'hFFFF) r_ovf <= 1'b1;
        end else begin
          r_rp <= r_rp - RPW'(1);
        end
      end
    end
  end

  // Scan prescaler free-runs in every state so the display never stalls.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sp       <= c_SP_INIT;
      r_scan_en  <= 1'b0;
      r_scan_sel <= 2'd0;
    end else if (r_sp == '0) begin
      r_sp       <= c_SP_INIT;
      r_scan_en  <= 1'b1;
      r_scan_sel <= (r_scan_sel == c_SEL_LAST) ? 2'd0 : r_scan_sel + 2'd1;
    end else begin
      r_sp       <= r_sp - SPW'(1);
      r_scan_en  <= 1'b0;
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign tick          = r_tick;
  assign running       = r_running;
  assign elapsed       = r_elapsed;
  assign ovf           = r_ovf;
  assign scan_en       = r_scan_en;
  assign scan_sel      = r_scan_sel;

endmodule

`default_nettype wire

// File: tb/tb_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timebase_ctrl : randomized and directed checks against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_timebase_ctrl;

  localparam int CLK_HZ   = 100;
  localparam int TICK_HZ  = 10;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = 3;
  localparam int DIGITS   = 4;
  localparam logic [22:0] c_RST_VEC = {1'b1, 22'd0};

  logic clkin = 1'b0;
  logic rst_n = 1'b1;
  always #5 clkin = ~clkin;

  timebase_ctrl_if cmd_if();

  logic        tick, running, ovf, scan_en;
  logic [15:0] elapsed;
  logic [1:0]  scan_sel;

  timebase_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .cmd(cmd_if),
    .tick(tick), .running(running), .elapsed(elapsed), .ovf(ovf),
    .scan_en(scan_en), .scan_sel(scan_sel)
  );

  logic [22:0] dut_vec;
  assign dut_vec = {cmd_if.cmd_ready, tick, running, ovf, scan_en, scan_sel, elapsed};

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 paused, 3 clearing.
  // Ticks fall on every DIV-th cycle spent running since the last clear.
  int   m_mode, m_runc, m_cyc, m_elapsed, m_sel, m_nm, m_op;
  logic m_ready, m_tick, m_running, m_ovf, m_scan_en, m_acc, m_clr;
  int   ld_seq = 0, ld_seen = 0, ld_val = 0;

  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_runc = 0; m_cyc = 0; m_elapsed = 0; m_sel = 0;
      m_ready = 1'b1; m_tick = 1'b0; m_running = 1'b0; m_ovf = 1'b0; m_scan_en = 1'b0;
    end else begin
      if (ld_seq != ld_seen) begin
        m_elapsed = ld_val;
        ld_seen   = ld_seq;
      end
      m_acc = cmd_if.cmd_valid && m_ready;
      m_op  = int'(cmd_if.cmd_op);
      m_clr = m_acc && (m_op == 3);
      m_cyc++;
      m_scan_en = ((m_cyc % SCAN_DIV) == 0);
      if (m_scan_en) m_sel = (m_sel + 1) % DIGITS;
      m_running = (m_mode == 1);
      m_tick    = 1'b0;
      if (m_mode == 1 && !m_clr) begin
        m_runc++;
        if ((m_runc % DIV) == 0) begin
          m_tick = 1'b1;
          if (m_elapsed == 65535) m_ovf = 1'b1;
          m_elapsed = (m_elapsed + 1) % 65536;
        end
      end
      m_nm = m_mode;
      if (m_mode == 3) m_nm = 0;
      else if (m_clr) begin
        m_nm = 3; m_elapsed = 0; m_ovf = 1'b0; m_runc = 0;
      end
      else if (m_acc && m_op == 1) m_nm = 1;
      else if (m_acc && m_op == 2 && m_mode == 1) m_nm = 2;
      m_mode  = m_nm;
      m_ready = (m_nm != 3);
    end
  end

  function automatic logic [22:0] exp_vec();
    return {m_ready, m_tick, m_running, m_ovf, m_scan_en, 2'(m_sel), 16'(m_elapsed)};
  endfunction

  // Inputs change only on the falling edge; each call ends on a falling edge.
  task automatic drive(input logic v, input logic [1:0] op);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic test_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    #2 rst_n = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    compared++;
    if (dut_vec !== c_RST_VEC) begin
      mismatched++;
      $display("FAIL reset_state got=%h want=%h", dut_vec, c_RST_VEC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tick_timing();
    drive(1'b1, 2'b01);
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, 2'b00);
      compared++;
      if (tick !== 1'((k % DIV) == 0)) begin
        mismatched++;
        $display("FAIL tick_edge k=%0d got=%b want=%b", k, tick, (k % DIV) == 0);
      end
      compared++;
      if (elapsed !== 16'(k / DIV)) begin
        mismatched++;
        $display("FAIL tick_elapsed k=%0d got=%0d want=%0d", k, elapsed, k / DIV);
      end
      compared++;
      if (running !== 1'b1) begin
        mismatched++;
        $display("FAIL tick_running k=%0d got=%b want=1", k, running);
      end
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL tick_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_pause_resume();
    drive(1'b1, 2'b11);
    drive(1'b0, 2'b00);
    drive(1'b1, 2'b01);
    repeat (13) drive(1'b0, 2'b00);
    drive(1'b1, 2'b10);
    compared++;
    if (elapsed !== 16'd1) begin
      mismatched++;
      $display("FAIL pause_elapsed got=%0d want=1", elapsed);
    end
    for (int k = 0; k < 50; k++) begin
      drive(1'b0, 2'b00);
      compared++;
      if (elapsed !== 16'd1 || tick !== 1'b0 || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL pause_hold k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
    end
    drive(1'b1, 2'b01);
    for (int j = 1; j <= 6; j++) begin
      drive(1'b0, 2'b00);
      compared++;
      if (tick !== 1'(j == 6) || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL resume_phase j=%0d got=%h want=%h", j, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic wait_terminal(input string tag);
    int n;
    n = 0;
    while ((m_runc % DIV) != DIV - 1 && n < 40) begin
      drive(1'b0, 2'b00);
      n++;
    end
    compared++;
    if (n >= 40) begin
      mismatched++;
      $display("FAIL %s timeout got=%0d want<40", tag, n);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] prev;
    wait_terminal("stop_edge");
    prev = elapsed;
    drive(1'b1, 2'b10);
    compared++;
    if (tick !== 1'b1 || elapsed !== prev + 16'd1) begin
      mismatched++;
      $display("FAIL stop_on_tick got tick=%b el=%0d want tick=1 el=%0d", tick, elapsed, prev + 16'd1);
    end
    drive(1'b0, 2'b00);
    compared++;
    if (running !== 1'b0 || tick !== 1'b0 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL stop_paused got=%h want=%h", dut_vec, exp_vec());
    end
    drive(1'b1, 2'b01);
    wait_terminal("clear_edge");
    drive(1'b1, 2'b11);
    compared++;
    if (tick !== 1'b0 || elapsed !== 16'd0 || cmd_if.cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_on_tick got tick=%b el=%0d rdy=%b want 0/0/0", tick, elapsed, cmd_if.cmd_ready);
    end
    drive(1'b1, 2'b01);
    compared++;
    if (cmd_if.cmd_ready !== 1'b1 || running !== 1'b0 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL clearing_exit got=%h want=%h", dut_vec, exp_vec());
    end
    drive(1'b1, 2'b01);
    compared++;
    if (running !== 1'b0) begin
      mismatched++;
      $display("FAIL clearing_blocks_cmd got running=%b want=0", running);
    end
    drive(1'b0, 2'b00);
    compared++;
    if (running !== 1'b1 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL start_after_clear got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_overflow();
    int seen, n;
    force dut.r_elapsed = 16'd65534;
    ld_val = 65534;
    ld_seq++;
    #1 release dut.r_elapsed;
    seen = 0;
    n = 0;
    while (seen < 2 && n < 30) begin
      drive(1'b0, 2'b00);
      if (tick === 1'b1) seen++;
      n++;
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL ovf_model n=%0d got=%h want=%h", n, dut_vec, exp_vec());
      end
    end
    compared++;
    if (elapsed !== 16'd0 || ovf !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_wrap got el=%0d ovf=%b want el=0 ovf=1", elapsed, ovf);
    end
    drive(1'b1, 2'b10);
    repeat (3) drive(1'b0, 2'b00);
    drive(1'b1, 2'b01);
    repeat (3) drive(1'b0, 2'b00);
    compared++;
    if (ovf !== 1'b1 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL ovf_sticky got=%h want=%h", dut_vec, exp_vec());
    end
    drive(1'b1, 2'b11);
    compared++;
    if (ovf !== 1'b0 || elapsed !== 16'd0) begin
      mismatched++;
      $display("FAIL ovf_clear got ovf=%b el=%0d want 0/0", ovf, elapsed);
    end
    drive(1'b0, 2'b00);
  endtask

  task automatic test_scan();
    int n;
    logic [1:0] s;
    n = 0;
    while (scan_en !== 1'b1 && n < 5) begin
      drive(1'b0, 2'b00);
      n++;
    end
    compared++;
    if (n >= 5) begin
      mismatched++;
      $display("FAIL scan_find timeout got=%0d want<5", n);
    end
    s = scan_sel;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 2'b00);
      compared++;
      if (scan_en !== 1'((k % SCAN_DIV) == 0) || scan_sel !== 2'((int'(s) + k / SCAN_DIV) % DIGITS)) begin
        mismatched++;
        $display("FAIL scan_seq k=%0d got en=%b sel=%0d want en=%b sel=%0d", k, scan_en, scan_sel,
                 (k % SCAN_DIV) == 0, (int'(s) + k / SCAN_DIV) % DIGITS);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int k = 0; k < 600; k++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 3) != 0) op = 2'b00;
      drive(1'($urandom_range(0, 1)), op);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL random k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b01);
    repeat (4) drive(1'b0, 2'b00);
    @(posedge clkin);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (dut_vec !== c_RST_VEC) begin
      mismatched++;
      $display("FAIL async_reset got=%h want=%h", dut_vec, c_RST_VEC);
    end
    @(negedge clkin);
    rst_n = 1'b1;
    drive(1'b1, 2'b01);
    for (int k = 1; k <= DIV; k++) begin
      drive(1'b0, 2'b00);
      compared++;
      if (tick !== 1'(k == DIV) || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL restart_period k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_timing();
    test_pause_resume();
    test_simultaneous();
    test_overflow();
    test_scan();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
